uart_tx_axis: RTL

//   UART transmitter, 8N1 by default. Accepts bytes on an AXI-Stream slave and serialises each one onto txd.
//   Bit timing matches the team's UART receiver: one bit lasts prescale*8 clk cycles.
//   A one-entry holding buffer lets consecutive frames go out with no idle gap.

---
 rtl/uart_tx_axis_if.sv | 13 +
 rtl/uart_tx_axis.sv | 121 ++++++++++++
 2 files changed

// File: rtl/uart_tx_axis_if.sv
// uart_tx_axis_if: AXI-Stream byte channel between a byte source and the UART transmitter
//   tdata  : byte to transmit (DATA_WIDTH bits)
//   tvalid : tdata is valid
//   tready : sink can accept a byte this cycle
interface uart_tx_axis_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  modport master (output tdata, tvalid, input tready);
  modport slave (input tdata, tvalid, output tready);
endinterface

// File: rtl/uart_tx_axis.sv
// uart_tx_axis: 8N1-style UART transmitter fed by an AXI-Stream slave with a one-entry holding buffer
//   clk, rst_n   : clock, asynchronous active-low reset
//   s_axis       : byte input channel (slave modport)
//   prescale_i   : bit period = prescale*8 clk cycles, 0 treated as 1, sampled at frame start
//   txd_o        : serial output, idles high
//   busy_o       : frame in progress or buffer occupied
//   frame_done_o : high during the final cycle of the last stop bit
//   tx_count_o   : frames sent since reset, wraps
module uart_tx_axis #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_axis_if.slave s_axis,
  input  logic [15:0]   prescale_i,
  output logic          txd_o,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic [7:0]    tx_count_o
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  logic [1:0]            state_q, state_d;
  logic [18:0]           timer_q, timer_d, period_q, period_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shifter_q, shifter_d, buf_q, buf_d;
  logic                  buf_valid_q, buf_valid_d;
  logic                  txd_q, txd_d, busy_q, busy_d, frame_done_q, frame_done_d;
  logic [7:0]            tx_count_q, tx_count_d;
  logic [15:0]           ps_eff;
  logic [18:0]           period_eff;
  logic                  tick, last_stop, launch;
  assign ps_eff        = (prescale_i == 16'd0) ? 16'd1 : prescale_i;
  assign period_eff    = {ps_eff, 3'b000} - 19'd1;
  assign tick          = (timer_q == 19'd0);
  assign last_stop     = (state_q == STOP) && tick && (stop_cnt_q == STOP_LAST);
  // a buffered byte starts a frame from IDLE or directly off the end of the previous stop bit
  assign launch        = buf_valid_q && ((state_q == IDLE) || last_stop);
  assign s_axis.tready = !buf_valid_q;
  always_comb begin
    state_d     = state_q;
    timer_d     = tick ? period_q : timer_q - 19'd1;
    period_d    = period_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shifter_d   = shifter_q;
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    tx_count_d  = last_stop ? tx_count_q + 8'd1 : tx_count_q;
    if (s_axis.tvalid && !buf_valid_q) begin
      buf_d       = s_axis.tdata;
      buf_valid_d = 1'b1;
    end
    if (tick) begin
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_cnt_d = BW'(DATA_WIDTH);
        end
        DATA: begin
          state_d    = (bit_cnt_q == BW'(1)) ? STOP : DATA;
          stop_cnt_d = 1'b0;
          shifter_d  = (bit_cnt_q == BW'(1)) ? shifter_q : shifter_q >> 1;
          bit_cnt_d  = bit_cnt_q - BW'(1);
        end
        STOP: begin
          state_d    = last_stop ? IDLE : STOP;
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
    if (launch) begin
      state_d     = START;
      shifter_d   = buf_q;
      buf_valid_d = 1'b0;
      period_d    = period_eff;
      timer_d     = period_eff;
    end
    // outputs are registered from the next state so they line up with the state they describe
    txd_d        = (state_d == START) ? 1'b0 : (state_d == DATA) ? shifter_d[0] : 1'b1;
    busy_d       = (state_d != IDLE) || buf_valid_d;
    frame_done_d = (state_d == STOP) && (timer_d == 19'd0) && (stop_cnt_d == STOP_LAST);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      period_q     <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shifter_q    <= '0;
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tx_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      period_q     <= period_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shifter_q    <= shifter_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      tx_count_q   <= tx_count_d;
    end
  end
  assign txd_o        = txd_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign tx_count_o   = tx_count_q;
endmodule
